sram_mp_ctrl: RTL and testbench

Multi-port asynchronous SRAM controller with round-robin arbitration. It is the parametrised successor of the single-CPU SRAM interface with its VGA bypass. NUM_PORTS requesters (CPU instruction, CPU data, VGA, DMA, ...) share one external 16-bit async SRAM over a uniform req/ack handshake. Each DATA_W word is split into MEM_W beats with programmable wait states and per-byte write enables.

---
 rtl/sram_mp_pkg.sv | 37 +++
 rtl/sram_rr_arbiter.sv | 33 +++
 rtl/sram_mp_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sram_mp_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mp_pkg.sv
// Shared types and helpers for the multi-port async SRAM controller.
//   state_t      : controller FSM states
//   calc_*       : derived widths (beats per word, SRAM address width, byte lanes, pointer width)
//   params_legal : elaboration-time sanity check of the parameter set
package sram_mp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int calc_beats(input int data_w, input int mem_w);
    return data_w / mem_w;
  endfunction

  function automatic int calc_lanes(input int mem_w);
    return mem_w / 32'sd8;
  endfunction

  function automatic int calc_saw(input int addr_w, input int mem_w);
    return addr_w - $clog2(mem_w / 32'sd8);
  endfunction

  function automatic int calc_ptr_w(input int num_ports);
    return (num_ports > 32'sd1) ? $clog2(num_ports) : 32'sd1;
  endfunction

  function automatic bit params_legal(input int num_ports, input int data_w, input int mem_w,
                                      input int addr_w, input int wait_cyc);
    return (num_ports >= 32'sd1) && (num_ports <= 32'sd8) &&
           (mem_w >= 32'sd8) && ((mem_w % 32'sd8) == 32'sd0) &&
           (data_w >= mem_w) && ((data_w % mem_w) == 32'sd0) &&
           (wait_cyc >= 32'sd1) && (addr_w > $clog2(data_w / 32'sd8));
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-port request vector
//   ptr   : port with highest priority this round (search runs upward, wrapping)
//   gnt   : one-hot grant
//   valid : at least one request present
module sram_rr_arbiter
  import sram_mp_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PTR_W     = calc_ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 valid
);

  // Walk ports starting at ptr; the first requester seen blocks all later ones.
  always_comb begin
    logic             hit;
    logic [PTR_W-1:0] idx;
    gnt = {NUM_PORTS{1'b0}};
    hit = 1'b0;
    idx = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx      = PTR_W'((int'(ptr) + i) % NUM_PORTS);
      gnt[idx] = req[idx] & ~hit;
      hit      = hit | req[idx];
    end
    valid = hit;
  end

endmodule

// File: rtl/sram_mp_ctrl.sv
// Multi-port async SRAM controller: NUM_PORTS requesters share one MEM_W-wide
// async SRAM. Each DATA_W word is moved as BEATS beats (most significant first),
// each beat lasting WAIT_CYC+1 cycles.
//   clk, rst            : clock, synchronous active-high reset
//   req/we/addr/wdata/be: per-port request bundle, sampled only for the granted port in IDLE
//   rdata/ack           : per-port read data (held between reads) and completion pulse
//   busy                : controller not in IDLE
//   sram_*              : registered SRAM pins; sram_data driven only during write beats
module sram_mp_ctrl
  import sram_mp_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 32,
  parameter int MEM_W     = 16,
  parameter int ADDR_W    = 24,
  parameter int WAIT_CYC  = 2,
  localparam int BEATS    = calc_beats(DATA_W, MEM_W),
  localparam int LANES    = calc_lanes(MEM_W),
  localparam int SAW      = calc_saw(ADDR_W, MEM_W),
  localparam int BYTES    = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*BYTES-1:0]  be,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic                        busy,
  output logic [SAW-1:0]              sram_addr,
  inout  wire  [MEM_W-1:0]            sram_data,
  output logic                        sram_ce_n,
  output logic                        sram_oe_n,
  output logic                        sram_we_n,
  output logic [LANES-1:0]            sram_be_n,
  output logic                        sram_clk,
  output logic                        sram_adv,
  output logic                        sram_cre
);

  localparam int AOFF   = $clog2(BYTES);
  localparam int WORD_W = ADDR_W - AOFF;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW     = $clog2(WAIT_CYC + 1);
  localparam int PW     = calc_ptr_w(NUM_PORTS);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(WAIT_CYC);

  if (!params_legal(NUM_PORTS, DATA_W, MEM_W, ADDR_W, WAIT_CYC)) begin : g_illegal
    $error("sram_mp_ctrl: illegal parameter set");
  end

  // Per-port views of the flat buses.
  logic [WORD_W-1:0] word_a  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_a [NUM_PORTS];
  logic [BYTES-1:0]  be_a    [NUM_PORTS];
  logic [DATA_W-1:0] rdata_r [NUM_PORTS];
  logic [DATA_W-1:0] rdata_s [NUM_PORTS];
  // Byte-offset bits inside a word carry no meaning for the SRAM.
  logic              unused_addr_s;
  assign unused_addr_s = ^addr;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign word_a[p]  = addr[p*ADDR_W+AOFF +: WORD_W];
    assign wdata_a[p] = wdata[p*DATA_W +: DATA_W];
    assign be_a[p]    = be[p*BYTES +: BYTES];
    assign rdata[p*DATA_W +: DATA_W] = rdata_r[p];
  end

  state_t            state_r, state_s;
  logic [BW-1:0]     beat_r, beat_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [PW-1:0]     gnt_r, gnt_s, ptr_r, ptr_s;
  logic              we_lat_r, we_lat_s;
  logic [WORD_W-1:0] word_lat_r, word_lat_s;
  logic [DATA_W-1:0] wdata_lat_r, wdata_lat_s, rbuf_r, rbuf_s;
  logic [BYTES-1:0]  be_lat_r, be_lat_s;
  logic [NUM_PORTS-1:0] ack_r, ack_s, arb_gnt_s;
  logic              arb_valid_s;
  logic [PW-1:0]     arb_idx_s;

  sram_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PTR_W(PW)) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // One-hot grant to port index.
  always_comb begin
    arb_idx_s = {PW{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      arb_idx_s = arb_idx_s | (PW'(p) & {PW{arb_gnt_s[PW'(p)]}});
    end
  end

  // FSM next state, beat/wait counting, request latching and read assembly.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    cnt_s       = cnt_r;
    gnt_s       = gnt_r;
    ptr_s       = ptr_r;
    we_lat_s    = we_lat_r;
    word_lat_s  = word_lat_r;
    wdata_lat_s = wdata_lat_r;
    be_lat_s    = be_lat_r;
    rbuf_s      = rbuf_r;
    rdata_s     = rdata_r;
    ack_s       = {NUM_PORTS{1'b0}};
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          gnt_s       = arb_idx_s;
          we_lat_s    = we[arb_idx_s];
          word_lat_s  = word_a[arb_idx_s];
          wdata_lat_s = wdata_a[arb_idx_s];
          be_lat_s    = be_a[arb_idx_s];
          beat_s      = {BW{1'b0}};
          cnt_s       = CNT_RELOAD;
          state_s     = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == {CW{1'b0}}) begin
          // Read beats arrive MSB-first, so shift the buffer up before inserting.
          if (!we_lat_r) begin
            rbuf_s = (rbuf_r << MEM_W) | DATA_W'(sram_data);
          end else begin
            rbuf_s = rbuf_r;
          end
          if (beat_r == LAST_BEAT) begin
            state_s       = DONE;
            ack_s[gnt_r]  = 1'b1;
            if (!we_lat_r) begin
              rdata_s[gnt_r] = rbuf_s;
            end else begin
              rdata_s = rdata_r;
            end
          end else begin
            beat_s = beat_r + BW'(1);
            cnt_s  = CNT_RELOAD;
          end
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      DONE: begin
        ptr_s   = (gnt_r == PW'(NUM_PORTS - 1)) ? {PW{1'b0}} : gnt_r + PW'(1);
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Per-beat write data and byte-enable slices, beat 0 = most significant.
  logic [MEM_W-1:0] wslice_s [BEATS];
  logic [LANES-1:0] bslice_s [BEATS];
  for (genvar k = 0; k < BEATS; k++) begin : g_slice
    assign wslice_s[k] = wdata_lat_s[DATA_W-1-k*MEM_W -: MEM_W];
    assign bslice_s[k] = be_lat_s[BYTES-1-k*LANES -: LANES];
  end

  logic             ce_n_r, oe_n_r, we_n_r, drive_r, busy_r;
  logic             ce_n_s, oe_n_s, we_n_s, drive_s;
  logic [LANES-1:0] be_n_r, be_n_s;
  logic [SAW-1:0]   saddr_r, saddr_s;
  logic [MEM_W-1:0] dout_r, dout_s;

  // Pin values for the upcoming cycle, derived from the next FSM state so that
  // the registered pins line up with the state they belong to. WE drops on the
  // cnt==0 cycle of each beat to give address/data hold time.
  always_comb begin
    ce_n_s  = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    be_n_s  = {LANES{1'b1}};
    drive_s = 1'b0;
    dout_s  = dout_r;
    saddr_s = saddr_r;
    if (state_s == ACCESS) begin
      ce_n_s  = 1'b0;
      saddr_s = SAW'(word_lat_s) * SAW'(BEATS) + SAW'(beat_s);
      if (we_lat_s) begin
        drive_s = 1'b1;
        dout_s  = wslice_s[beat_s];
        be_n_s  = ~bslice_s[beat_s];
        we_n_s  = ~((cnt_s != {CW{1'b0}}) && (|bslice_s[beat_s]));
      end else begin
        oe_n_s = 1'b0;
        be_n_s = {LANES{1'b0}};
      end
    end else begin
      drive_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, pointer and registered output pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r      <= {BW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      gnt_r       <= {PW{1'b0}};
      ptr_r       <= {PW{1'b0}};
      we_lat_r    <= 1'b0;
      word_lat_r  <= {WORD_W{1'b0}};
      wdata_lat_r <= {DATA_W{1'b0}};
      be_lat_r    <= {BYTES{1'b0}};
      rbuf_r      <= {DATA_W{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) rdata_r[p] <= {DATA_W{1'b0}};
      ack_r       <= {NUM_PORTS{1'b0}};
      busy_r      <= 1'b0;
      ce_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      be_n_r      <= {LANES{1'b1}};
      drive_r     <= 1'b0;
      dout_r      <= {MEM_W{1'b0}};
      saddr_r     <= {SAW{1'b0}};
    end else begin
      beat_r      <= beat_s;
      cnt_r       <= cnt_s;
      gnt_r       <= gnt_s;
      ptr_r       <= ptr_s;
      we_lat_r    <= we_lat_s;
      word_lat_r  <= word_lat_s;
      wdata_lat_r <= wdata_lat_s;
      be_lat_r    <= be_lat_s;
      rbuf_r      <= rbuf_s;
      rdata_r     <= rdata_s;
      ack_r       <= ack_s;
      busy_r      <= (state_s != IDLE);
      ce_n_r      <= ce_n_s;
      oe_n_r      <= oe_n_s;
      we_n_r      <= we_n_s;
      be_n_r      <= be_n_s;
      drive_r     <= drive_s;
      dout_r      <= dout_s;
      saddr_r     <= saddr_s;
    end
  end

  assign ack       = ack_r;
  assign busy      = busy_r;
  assign sram_addr = saddr_r;
  assign sram_ce_n = ce_n_r;
  assign sram_oe_n = oe_n_r;
  assign sram_we_n = we_n_r;
  assign sram_be_n = be_n_r;
  assign sram_data = drive_r ? dout_r : {MEM_W{1'bz}};
  assign sram_clk  = 1'b0;
  assign sram_adv  = 1'b0;
  assign sram_cre  = 1'b0;

endmodule

// File: tb/tb_sram_mp_ctrl.sv
// Scoreboard bench for sram_mp_ctrl with a behavioural async SRAM model.
module tb_sram_mp_ctrl;

  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we_v;
  logic [23:0] addr_a  [NP];
  logic [31:0] wdata_a [NP];
  logic [3:0]  be_a    [NP];
  logic [71:0] addr;
  logic [95:0] wdata;
  logic [11:0] be;
  logic [95:0] rdata;
  logic [2:0]  ack;
  logic        busy;
  logic [22:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_clk, sram_adv, sram_cre;
  logic [1:0]  sram_be_n;
  logic [31:0] rd_a [NP];

  assign addr  = {addr_a[2], addr_a[1], addr_a[0]};
  assign wdata = {wdata_a[2], wdata_a[1], wdata_a[0]};
  assign be    = {be_a[2], be_a[1], be_a[0]};
  assign rd_a[0] = rdata[31:0];
  assign rd_a[1] = rdata[63:32];
  assign rd_a[2] = rdata[95:64];

  sram_mp_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we_v), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .ack(ack), .busy(busy), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_clk(sram_clk), .sram_adv(sram_adv), .sram_cre(sram_cre)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Async SRAM model: 256 words, reads drive the bus while CE and OE are low.
  logic [15:0] mem [256];
  bit          loaded = 1'b0;
  int          oe_low = 0;
  int          we_low = 0;
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'bz;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h08] = 16'hDEAD;  mem[8'h09] = 16'hBEEF;
      mem[8'h0C] = 16'h1111;  mem[8'h0D] = 16'h2222;
      mem[8'h0E] = 16'h3333;  mem[8'h0F] = 16'h4444;
      loaded = 1'b1;
    end else begin
      if (!sram_ce_n && !sram_oe_n) oe_low++;
      if (!sram_ce_n && !sram_we_n) begin
        we_low++;
        if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] = sram_data[15:8];
        if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0]  = sram_data[7:0];
      end
    end
  end

  // Scoreboard of expected acks.
  typedef struct {
    int          port;
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  task automatic expect_ack(input int port, input int at, input bit rd, input logic [31:0] data);
    exp_t e;
    e.port = port; e.cyc = at; e.rd = rd; e.data = data;
    q.push_back(e);
  endtask

  // Monitor: every ack pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (ack[p[1:0]]) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 64'(p), 64'hFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_port", 64'(p), 64'(e.port));
          chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          if (e.rd) chk("ack_rdata", 64'(rd_a[p]), 64'(e.data));
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_port(input int p, input bit w, input logic [23:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    we_v[p[1:0]] = w; addr_a[p] = a; wdata_a[p] = d; be_a[p] = b;
  endtask

  int c, oe0, we0;

  initial begin
    rst = 1'b1; req = 3'b000; we_v = 3'b000;
    set_port(0, 1'b0, 24'h000010, 32'h0, 4'hF);
    set_port(1, 1'b0, 24'h000018, 32'h0, 4'hF);
    set_port(2, 1'b0, 24'h00001C, 32'h0, 4'hF);
    req = 3'b111;
    repeat (3) @(negedge clk);

    // Reset state with all requests asserted
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n}), 64'h7);
    chk("rst_be_n", 64'(sram_be_n), 64'h3);
    chk("rst_addr", 64'(sram_addr), 64'h0);
    chk("rst_rdata", 64'(rdata[63:0]), 64'h0);
    chk("rst_tied", 64'({sram_clk, sram_adv, sram_cre}), 64'h0);

    // Round robin with all three ports re-requesting
    c = cyc;
    rst = 1'b0;
    expect_ack(0, c + 7,  1'b1, 32'hDEADBEEF);
    expect_ack(1, c + 15, 1'b1, 32'h11112222);
    expect_ack(2, c + 23, 1'b1, 32'h33334444);
    expect_ack(0, c + 31, 1'b1, 32'hDEADBEEF);
    expect_ack(1, c + 39, 1'b1, 32'h11112222);
    expect_ack(2, c + 47, 1'b1, 32'h33334444);
    wait_until(c + 47);
    req = 3'b000;
    @(negedge clk);

    // Port 1 read of 0xDEADBEEF
    c = cyc; oe0 = oe_low; we0 = we_low;
    set_port(1, 1'b0, 24'h000010, 32'h0, 4'hF);
    req[1] = 1'b1;
    expect_ack(1, c + 7, 1'b1, 32'hDEADBEEF);
    wait_until(c + 7);
    req[1] = 1'b0;
    @(negedge clk);
    chk("rd_oe_cycles", 64'(oe_low - oe0), 64'd6);
    chk("rd_we_cycles", 64'(we_low - we0), 64'd0);

    // Port 0 full-word write
    c = cyc; oe0 = oe_low; we0 = we_low;
    set_port(0, 1'b1, 24'h000020, 32'h12345678, 4'hF);
    req[0] = 1'b1;
    expect_ack(0, c + 7, 1'b0, 32'h0);
    wait_until(c + 7);
    req[0] = 1'b0;
    @(negedge clk);
    chk("wr_we_cycles", 64'(we_low - we0), 64'd4);
    chk("wr_oe_cycles", 64'(oe_low - oe0), 64'd0);
    chk("wr_mem_hi", 64'(mem[8'h10]), 64'h1234);
    chk("wr_mem_lo", 64'(mem[8'h11]), 64'h5678);
    chk("rdata1_hold", 64'(rd_a[1]), 64'hDEADBEEF);
    chk("rdata0_hold", 64'(rd_a[0]), 64'hDEADBEEF);

    // Port 2 single-byte write: beat 0 has no enables
    c = cyc; we0 = we_low;
    set_port(2, 1'b1, 24'h000020, 32'hAABBCCDD, 4'b0010);
    req[2] = 1'b1;
    expect_ack(2, c + 7, 1'b0, 32'h0);
    wait_until(c + 7);
    req[2] = 1'b0;
    @(negedge clk);
    chk("be_we_cycles", 64'(we_low - we0), 64'd2);
    chk("be_mem_hi", 64'(mem[8'h10]), 64'h1234);
    chk("be_mem_lo", 64'(mem[8'h11]), 64'hCC78);

    // Port 0 alone re-requesting every 8 cycles
    c = cyc;
    set_port(0, 1'b0, 24'h000020, 32'h0, 4'hF);
    req[0] = 1'b1;
    expect_ack(0, c + 7,  1'b1, 32'h1234CC78);
    expect_ack(0, c + 15, 1'b1, 32'h1234CC78);
    expect_ack(0, c + 23, 1'b1, 32'h1234CC78);
    wait_until(c + 23);
    req[0] = 1'b0;
    @(negedge clk);

    // Reset during beat 1 of a write; held request restarts from beat 0
    c = cyc;
    set_port(1, 1'b1, 24'h000030, 32'h0BADF00D, 4'hF);
    req[1] = 1'b1;
    wait_until(c + 4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we_n", 64'(sram_we_n), 64'h1);
    chk("abort_ce_n", 64'(sram_ce_n), 64'h1);
    chk("abort_ack", 64'(ack), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_rdata", 64'(rdata[95:32]), 64'h0);
    chk("abort_rdata0", 64'(rd_a[0]), 64'h0);
    we0 = we_low;
    rst = 1'b0;
    expect_ack(1, c + 12, 1'b0, 32'h0);
    wait_until(c + 12);
    req[1] = 1'b0;
    @(negedge clk);
    chk("restart_we_cycles", 64'(we_low - we0), 64'd4);
    chk("restart_mem_hi", 64'(mem[8'h18]), 64'h0BAD);
    chk("restart_mem_lo", 64'(mem[8'h19]), 64'hF00D);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
